// File: rtl/disp_pkg.sv
// Shared constants for the binary-to-7-segment display controller:
// FSM state encodings and active-low segment patterns (segment order gfedcba).
package disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bin_display_ctrl_if.sv
// Request/status bundle between the switch/datapath side (master) and the
// display controller (slave).
interface bin_display_ctrl_if #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [7*DIGITS-1:0]   seg_out;

    modport master (
        output start, bin_in,
        input  busy, done, overflow, seg_out
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow, seg_out
    );
endinterface

// File: rtl/seg_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal
// nibbles produce a blank display.
module seg_decoder
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_display_ctrl.sv
// Iterative double-dabble binary-to-BCD converter feeding one time-shared
// 7-segment decoder. Optional macro: LEADING_ZERO_BLANK_EN.
module bin_display_ctrl
    import disp_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bin_display_ctrl_if.slave  bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]          state;
    logic [WIDTH-1:0]    bin_sh;
    logic [BW-1:0]       bcd;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                ovf;
    logic [7*DIGITS-1:0] seg;

    logic [BW-1:0]       corr;
    logic [BW-1:0]       bcd_next;
    logic [WIDTH-1:0]    bin_next;
    logic                out_bit;
    logic [3:0]          cur_nib;
    logic [6:0]          dec_seg;
    logic [6:0]          slice_val;

    // Add-3 correction on every nibble, then shift {bcd, bin} left by one.
    always_comb begin
        corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                corr[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                corr[4*i +: 4] = bcd[4*i +: 4];
        end
        bcd_next = {corr[BW-2:0], bin_sh[WIDTH-1]};
        bin_next = {bin_sh[WIDTH-2:0], 1'b0};
        out_bit  = corr[BW-1];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] zero_from;
    logic              cur_lz;

    // zero_from[i] is set when digit i and every higher digit are zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (bcd[BW-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--)
            zero_from[i] = zero_from[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
`endif

    always_comb begin
        cur_nib = '0;
`ifdef LEADING_ZERO_BLANK_EN
        cur_lz  = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                cur_lz  = (i != 0) && zero_from[i];
`endif
            end
        end
    end

    seg_decoder u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

    always_comb begin
        if (ovf)
            slice_val = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
        else if (cur_lz)
            slice_val = SEG_BLANK;
`endif
        else
            slice_val = dec_seg;
    end

    // SHIFT spends one extra cycle at cnt==0 before handing over to SCAN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            bin_sh <= '0;
            bcd    <= '0;
            cnt    <= '0;
            idx    <= '0;
            ovf    <= 1'b0;
            seg    <= {DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bin_sh <= bus.bin_in;
                        bcd    <= '0;
                        ovf    <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        idx   <= '0;
                        state <= ST_SCAN;
                    end else begin
                        bcd    <= bcd_next;
                        bin_sh <= bin_next;
                        cnt    <= cnt - 1'b1;
                        if (out_bit)
                            ovf <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i))
                            seg[7*i +: 7] <= slice_val;
                    end
                    if (idx == IW'(DIGITS - 1))
                        state <= ST_DONE;
                    else
                        idx <= idx + 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.overflow = ovf;
    assign bus.seg_out  = seg;

endmodule

// File: tb/tb_bin_display_ctrl.sv
// Directed bench for bin_display_ctrl: a 3-digit instance (a) and a 2-digit
// instance (b) that can overflow, sharing clock and reset.
module tb_bin_display_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bin_display_ctrl_if #(.WIDTH(9), .DIGITS(3)) bus_a ();
    bin_display_ctrl_if #(.WIDTH(9), .DIGITS(2)) bus_b ();

    bin_display_ctrl #(.WIDTH(9), .DIGITS(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    bin_display_ctrl #(.WIDTH(9), .DIGITS(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse start on instance sel (0=a, 1=b) with value v, then wait for done.
    // cycles is the number of negedges from the start-sampling edge to done.
    task automatic applyStimulus(input int sel, input logic [8:0] v, output int cycles);
        @(negedge clk);
        if (sel == 0) begin bus_a.bin_in = v; bus_a.start = 1'b1; end
        else          begin bus_b.bin_in = v; bus_b.start = 1'b1; end
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        cycles = 0;
        while (((sel == 0) ? bus_a.done : bus_b.done) !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 40) cycles = 999;
    endtask

    int cyc;
    int done_cnt;

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus_a.start = 1'b0; bus_a.bin_in = '0;
        bus_b.start = 1'b0; bus_b.bin_in = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_seg",  32'(bus_a.seg_out),  32'h1FFFFF);
        checkOutput("rst_busy", 32'(bus_a.busy),     32'h0);
        checkOutput("rst_done", 32'(bus_a.done),     32'h0);
        checkOutput("rst_ovf",  32'(bus_a.overflow), 32'h0);
        rst_n = 1'b1;

        // 123
        applyStimulus(0, 9'd123, cyc);
        checkOutput("lat_123", 32'(cyc), 32'd13);
        checkOutput("seg_123", 32'(bus_a.seg_out), 32'({7'b1111001, 7'b0100100, 7'b0110000}));
        checkOutput("ovf_123", 32'(bus_a.overflow), 32'h0);
        @(negedge clk);
        checkOutput("done_1cyc", 32'(bus_a.done), 32'h0);
        checkOutput("idle_busy", 32'(bus_a.busy), 32'h0);

        // Maximum value
        applyStimulus(0, 9'd511, cyc);
        checkOutput("lat_511", 32'(cyc), 32'd13);
        checkOutput("seg_511", 32'(bus_a.seg_out), 32'({7'b0010010, 7'b1111001, 7'b1111001}));
        checkOutput("ovf_511", 32'(bus_a.overflow), 32'h0);

        // Zero
        applyStimulus(0, 9'd0, cyc);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("seg_0", 32'(bus_a.seg_out), 32'({7'b1111111, 7'b1111111, 7'b1000000}));
`else
        checkOutput("seg_0", 32'(bus_a.seg_out), 32'({7'b1000000, 7'b1000000, 7'b1000000}));
`endif

        // Start while busy is ignored
        @(negedge clk);
        bus_a.bin_in = 9'd250; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        checkOutput("busy_run", 32'(bus_a.busy), 32'h1);
        done_cnt = 0;
        for (int i = 0; i < 35; i++) begin
            if (i == 3) begin bus_a.bin_in = 9'd99; bus_a.start = 1'b1; end
            if (i == 4) bus_a.start = 1'b0;
            @(negedge clk);
            if (bus_a.done === 1'b1) done_cnt++;
        end
        checkOutput("one_done", 32'(done_cnt), 32'd1);
        checkOutput("seg_250", 32'(bus_a.seg_out), 32'({7'b0100100, 7'b0010010, 7'b1000000}));

        // Start after done is accepted
        applyStimulus(0, 9'd7, cyc);
        checkOutput("lat_7", 32'(cyc), 32'd13);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("seg_7", 32'(bus_a.seg_out), 32'({7'b1111111, 7'b1111111, 7'b1111000}));
`else
        checkOutput("seg_7", 32'(bus_a.seg_out), 32'({7'b1000000, 7'b1000000, 7'b1111000}));
`endif

        // Two-digit instance: overflow and recovery
        applyStimulus(1, 9'd150, cyc);
        checkOutput("lat_b150", 32'(cyc), 32'd12);
        checkOutput("ovf_b150", 32'(bus_b.overflow), 32'h1);
        checkOutput("seg_b150", 32'(bus_b.seg_out), 32'({7'b0111111, 7'b0111111}));
        applyStimulus(1, 9'd42, cyc);
        checkOutput("ovf_b42", 32'(bus_b.overflow), 32'h0);
        checkOutput("seg_b42", 32'(bus_b.seg_out), 32'({7'b0011001, 7'b0100100}));
        applyStimulus(1, 9'd99, cyc);
        checkOutput("ovf_b99", 32'(bus_b.overflow), 32'h0);
        checkOutput("seg_b99", 32'(bus_b.seg_out), 32'({7'b0010000, 7'b0010000}));
        applyStimulus(1, 9'd100, cyc);
        checkOutput("ovf_b100", 32'(bus_b.overflow), 32'h1);
        checkOutput("seg_b100", 32'(bus_b.seg_out), 32'({7'b0111111, 7'b0111111}));

        // Mid-operation reset
        @(negedge clk);
        bus_a.bin_in = 9'd123; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy", 32'(bus_a.busy), 32'h0);
        checkOutput("mid_seg",  32'(bus_a.seg_out), 32'h1FFFFF);
        checkOutput("mid_bseg", 32'(bus_b.seg_out), 32'h3FFF);
        checkOutput("mid_bovf", 32'(bus_b.overflow), 32'h0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) done_cnt++;
        end
        checkOutput("mid_nodone", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
